// File: rtl/stack_seq_pkg.sv
// Shared types for the Forth stack-word sequencer: command words, memory ops, FSM states.
package stack_seq_pkg;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_PUSH, CMD_DROP, CMD_DUP, CMD_SWAP, CMD_OVER, CMD_ROT, CMD_NIP
  } ss_cmd_t;

  typedef enum logic [1:0] {SS_NOP, SS_PUSH, SS_POP} stack_ops;

  typedef enum logic [1:0] {IDLE, POP_WAIT, POP_WAIT_ROT} seq_state_t;

  // Minimum stack depth a word needs before it may act.
  function automatic logic [1:0] cmd_need(ss_cmd_t c);
    case (c)
      CMD_DROP, CMD_DUP:            cmd_need = 2'd1;
      CMD_SWAP, CMD_OVER, CMD_NIP:  cmd_need = 2'd2;
      CMD_ROT:                      cmd_need = 2'd3;
      default:                      cmd_need = 2'd0;
    endcase
  endfunction

  function automatic logic cmd_grows(ss_cmd_t c);
    cmd_grows = (c == CMD_PUSH) || (c == CMD_DUP) || (c == CMD_OVER);
  endfunction

endpackage

// File: rtl/stack_seq_if.sv
// Command-side valid/ready handshake into the stack sequencer.
interface stack_seq_if #(parameter int DSZ = 32);
  import stack_seq_pkg::*;

  ss_cmd_t        cmd;
  logic           cmd_vld;
  logic           cmd_rdy;
  logic [DSZ-1:0] lit;

  modport master (output cmd, cmd_vld, lit, input cmd_rdy);
  modport slave  (input cmd, cmd_vld, lit, output cmd_rdy);
endinterface

// File: rtl/stack_seq.sv
// Forth stack-word sequencer: TOS/NOS cached in registers, deeper elements spilled
// to a single-port stack memory with at most one push or pop per cycle.
module stack_seq
  import stack_seq_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int DSZ   = 32,
  parameter int CSZ   = $clog2(DEPTH+3)
) (
  input  logic           clk,
  input  logic           rst_n,
  stack_seq_if.slave     cif,
  output logic [DSZ-1:0] tos,
  output logic [DSZ-1:0] nos,
  output logic [CSZ-1:0] depth,
  output logic           err_uf,
  output logic           err_of,
  input  logic           err_clr,
  output stack_ops       ss_op,
  output logic [DSZ-1:0] ss_vi,
  input  logic [DSZ-1:0] ss_q
);

  localparam logic [CSZ-1:0] DMAX = CSZ'(DEPTH+2);

  seq_state_t state, state_nx;
  logic acc, uf, of, go, mem_used, two_up;

  assign cif.cmd_rdy = (state == IDLE);
  assign acc      = cif.cmd_vld & cif.cmd_rdy;
  assign uf       = acc & (depth < CSZ'(cmd_need(cif.cmd)));
  assign of       = acc & cmd_grows(cif.cmd) & (depth == DMAX);
  assign go       = acc & ~uf & ~of;
  assign mem_used = depth > CSZ'(2);
  assign two_up   = depth >= CSZ'(2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Wait states always last exactly one cycle.
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE && go) begin
      case (cif.cmd)
        CMD_DROP, CMD_NIP: if (mem_used) state_nx = POP_WAIT;
        CMD_ROT:           state_nx = POP_WAIT_ROT;
        default:           state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    ss_op = SS_NOP;
    ss_vi = '0;
    case (state)
      IDLE: if (go) begin
        case (cif.cmd)
          CMD_PUSH, CMD_DUP: if (two_up) begin ss_op = SS_PUSH; ss_vi = nos; end
          CMD_OVER:          begin ss_op = SS_PUSH; ss_vi = nos; end
          CMD_DROP, CMD_NIP: if (mem_used) ss_op = SS_POP;
          CMD_ROT:           ss_op = SS_POP;
          default:           ss_op = SS_NOP;
        endcase
      end
      // nos still holds the old 'b' of (a b c) here; it goes back to memory.
      POP_WAIT_ROT: begin ss_op = SS_PUSH; ss_vi = nos; end
      default: ss_op = SS_NOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos   <= '0;
      nos   <= '0;
      depth <= '0;
    end else begin
      case (state)
        POP_WAIT:     nos <= ss_q;
        POP_WAIT_ROT: begin tos <= ss_q; nos <= tos; end
        default: if (go) begin
          case (cif.cmd)
            CMD_PUSH: begin nos <= tos; tos <= cif.lit; depth <= depth + CSZ'(1); end
            CMD_DUP:  begin nos <= tos; depth <= depth + CSZ'(1); end
            CMD_OVER: begin nos <= tos; tos <= nos; depth <= depth + CSZ'(1); end
            CMD_SWAP: begin nos <= tos; tos <= nos; end
            CMD_DROP: begin tos <= nos; depth <= depth - CSZ'(1); end
            CMD_NIP:  depth <= depth - CSZ'(1);
            default:  ;
          endcase
        end
      endcase
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_uf <= 1'b0;
      err_of <= 1'b0;
    end else begin
      err_uf <= uf | (err_uf & ~err_clr);
      err_of <= of | (err_of & ~err_clr);
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq with a behavioural downstream stack memory and a memory-op scoreboard.
module tb_stack_seq;
  import stack_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int DSZ   = 32;
  localparam int CSZ   = $clog2(DEPTH+3);
  localparam int CAP   = DEPTH + 2;

  typedef struct { stack_ops op; logic [DSZ-1:0] vi; } sb_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [DSZ-1:0] tos, nos, ss_vi, ss_q;
  logic [CSZ-1:0] depth;
  logic           err_uf, err_of, err_clr;
  stack_ops       ss_op;

  stack_seq_if #(.DSZ(DSZ)) cif ();

  stack_seq #(.DEPTH(DEPTH), .DSZ(DSZ)) dut (
    .clk(clk), .rst_n(rst_n), .cif(cif),
    .tos(tos), .nos(nos), .depth(depth),
    .err_uf(err_uf), .err_of(err_of), .err_clr(err_clr),
    .ss_op(ss_op), .ss_vi(ss_vi), .ss_q(ss_q)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  sb_t sbq[$];

  // Downstream stack memory: pop data appears the cycle after SS_POP.
  logic [DSZ-1:0] mem_q[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q.delete();
      ss_q <= '0;
    end else if (ss_op == SS_PUSH) begin
      mem_q.push_back(ss_vi);
    end else if (ss_op == SS_POP && mem_q.size() > 0) begin
      ss_q <= mem_q.pop_back();
    end
  end

  // Every issued memory op must match the next predicted one.
  always @(negedge clk) begin
    #2;
    if (rst_n && ss_op != SS_NOP) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL mem_op_unexpected: got op=%0d vi=%0d, none predicted", ss_op, ss_vi);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        if (ss_op !== e.op || (e.op == SS_PUSH && ss_vi !== e.vi)) begin
          n_bad++;
          $display("FAIL mem_op: got op=%0d vi=%0d want op=%0d vi=%0d", ss_op, ss_vi, e.op, e.vi);
        end
      end
    end
  end

  // Register-level reference model of the sequencer.
  logic [DSZ-1:0] m_tos, m_nos;
  logic [DSZ-1:0] m_mem[$];
  int             m_depth;

  task automatic model_clear();
    m_tos = '0; m_nos = '0; m_depth = 0;
    m_mem.delete();
    sbq.delete();
  endtask

  task automatic model_apply(input ss_cmd_t c, input logic [DSZ-1:0] l);
    int need;
    logic [DSZ-1:0] t;
    bit grows;
    case (c)
      CMD_DROP, CMD_DUP:           need = 1;
      CMD_SWAP, CMD_OVER, CMD_NIP: need = 2;
      CMD_ROT:                     need = 3;
      default:                     need = 0;
    endcase
    grows = (c == CMD_PUSH || c == CMD_DUP || c == CMD_OVER);
    if (m_depth < need || (grows && m_depth == CAP)) return;
    case (c)
      CMD_PUSH: begin
        if (m_depth >= 2) begin sbq.push_back('{SS_PUSH, m_nos}); m_mem.push_back(m_nos); end
        m_nos = m_tos; m_tos = l; m_depth++;
      end
      CMD_DUP: begin
        if (m_depth >= 2) begin sbq.push_back('{SS_PUSH, m_nos}); m_mem.push_back(m_nos); end
        m_nos = m_tos; m_depth++;
      end
      CMD_OVER: begin
        sbq.push_back('{SS_PUSH, m_nos}); m_mem.push_back(m_nos);
        t = m_tos; m_tos = m_nos; m_nos = t; m_depth++;
      end
      CMD_SWAP: begin t = m_tos; m_tos = m_nos; m_nos = t; end
      CMD_DROP, CMD_NIP: begin
        if (c == CMD_DROP) m_tos = m_nos;
        if (m_depth > 2) begin sbq.push_back('{SS_POP, '0}); m_nos = m_mem.pop_back(); end
        m_depth--;
      end
      CMD_ROT: begin
        sbq.push_back('{SS_POP, '0});
        t = m_mem.pop_back();
        sbq.push_back('{SS_PUSH, m_nos});
        m_mem.push_back(m_nos);
        m_nos = m_tos; m_tos = t;
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cif.cmd = CMD_NOP; cif.cmd_vld = 1'b0; cif.lit = '0; err_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // Issue one word; ew is the number of cycles cmd_rdy is expected low afterwards.
  task automatic do_cmd(input ss_cmd_t c, input logic [DSZ-1:0] l, input bit clr, input bit ew);
    @(negedge clk);
    n_cmp++;
    if (cif.cmd_rdy !== 1'b1) begin n_bad++; $display("FAIL rdy_pre: got %b want 1 (cmd %0d)", cif.cmd_rdy, c); end
    cif.cmd = c; cif.lit = l; cif.cmd_vld = 1'b1; err_clr = clr;
    model_apply(c, l);
    @(negedge clk);
    cif.cmd_vld = 1'b0; cif.cmd = CMD_NOP; err_clr = 1'b0;
    if (ew) begin
      n_cmp++;
      if (cif.cmd_rdy !== 1'b0) begin n_bad++; $display("FAIL rdy_wait: got %b want 0 (cmd %0d)", cif.cmd_rdy, c); end
      @(negedge clk);
    end
    n_cmp++;
    if (cif.cmd_rdy !== 1'b1) begin n_bad++; $display("FAIL rdy_post: got %b want 1 (cmd %0d)", cif.cmd_rdy, c); end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (tos !== '0 || nos !== '0 || depth !== '0) begin
      n_bad++; $display("FAIL reset_regs: got tos=%0d nos=%0d depth=%0d want 0/0/0", tos, nos, depth);
    end
    n_cmp++;
    if (err_uf !== 1'b0 || err_of !== 1'b0) begin
      n_bad++; $display("FAIL reset_err: got uf=%b of=%b want 0/0", err_uf, err_of);
    end
    n_cmp++;
    if (ss_op !== SS_NOP || ss_vi !== '0 || cif.cmd_rdy !== 1'b1) begin
      n_bad++; $display("FAIL reset_out: got op=%0d vi=%0d rdy=%b want 0/0/1", ss_op, ss_vi, cif.cmd_rdy);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    for (int i = 1; i <= 4; i++) do_cmd(CMD_PUSH, DSZ'(i), 1'b0, 1'b0);
    n_cmp++;
    if (tos !== 32'd4 || nos !== 32'd3 || depth !== 3'd4) begin
      n_bad++; $display("FAIL push4: got tos=%0d nos=%0d depth=%0d want 4/3/4", tos, nos, depth);
    end
    do_cmd(CMD_DROP, '0, 1'b0, 1'b1);
    do_cmd(CMD_DROP, '0, 1'b0, 1'b1);
    n_cmp++;
    if (tos !== 32'd2 || nos !== 32'd1 || depth !== 3'd2) begin
      n_bad++; $display("FAIL drop2: got tos=%0d nos=%0d depth=%0d want 2/1/2", tos, nos, depth);
    end
    do_cmd(CMD_DROP, '0, 1'b0, 1'b0);
    n_cmp++;
    if (tos !== 32'd1 || depth !== 3'd1) begin
      n_bad++; $display("FAIL drop3: got tos=%0d depth=%0d want 1/1", tos, depth);
    end
  endtask

  task automatic test_rot();
    do_reset();
    do_cmd(CMD_PUSH, 32'd10, 1'b0, 1'b0);
    do_cmd(CMD_PUSH, 32'd20, 1'b0, 1'b0);
    do_cmd(CMD_PUSH, 32'd30, 1'b0, 1'b0);
    do_cmd(CMD_ROT, '0, 1'b0, 1'b1);
    n_cmp++;
    if (tos !== 32'd10 || nos !== 32'd30 || depth !== 3'd3) begin
      n_bad++; $display("FAIL rot: got tos=%0d nos=%0d depth=%0d want 10/30/3", tos, nos, depth);
    end
    n_cmp++;
    if (mem_q.size() != 1 || mem_q[0] !== 32'd20) begin
      n_bad++; $display("FAIL rot_mem: got size=%0d top=%0d want 1/20", mem_q.size(),
                        mem_q.size() > 0 ? mem_q[mem_q.size()-1] : 32'hx);
    end
  endtask

  task automatic test_reg_words();
    do_reset();
    do_cmd(CMD_PUSH, 32'd5, 1'b0, 1'b0);
    do_cmd(CMD_PUSH, 32'd6, 1'b0, 1'b0);
    do_cmd(CMD_OVER, '0, 1'b0, 1'b0);
    n_cmp++;
    if (tos !== 32'd5 || nos !== 32'd6 || depth !== 3'd3) begin
      n_bad++; $display("FAIL over: got tos=%0d nos=%0d depth=%0d want 5/6/3", tos, nos, depth);
    end
    do_cmd(CMD_SWAP, '0, 1'b0, 1'b0);
    n_cmp++;
    if (tos !== 32'd6 || nos !== 32'd5 || depth !== 3'd3) begin
      n_bad++; $display("FAIL swap: got tos=%0d nos=%0d depth=%0d want 6/5/3", tos, nos, depth);
    end
    do_cmd(CMD_NIP, '0, 1'b0, 1'b1);
    n_cmp++;
    if (tos !== 32'd6 || nos !== 32'd5 || depth !== 3'd2) begin
      n_bad++; $display("FAIL nip: got tos=%0d nos=%0d depth=%0d want 6/5/2", tos, nos, depth);
    end
    do_cmd(CMD_DUP, '0, 1'b0, 1'b0);
    n_cmp++;
    if (tos !== m_tos || nos !== m_nos || depth !== CSZ'(m_depth)) begin
      n_bad++; $display("FAIL dup: got tos=%0d nos=%0d depth=%0d want %0d/%0d/%0d",
                        tos, nos, depth, m_tos, m_nos, m_depth);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    do_cmd(CMD_DROP, '0, 1'b0, 1'b0);
    n_cmp++;
    if (err_uf !== 1'b1 || depth !== 3'd0) begin
      n_bad++; $display("FAIL uf_drop: got uf=%b depth=%0d want 1/0", err_uf, depth);
    end
    do_cmd(CMD_NOP, '0, 1'b1, 1'b0);
    n_cmp++;
    if (err_uf !== 1'b0) begin n_bad++; $display("FAIL uf_clr: got %b want 0", err_uf); end
    do_cmd(CMD_PUSH, 32'd7, 1'b0, 1'b0);
    do_cmd(CMD_SWAP, '0, 1'b0, 1'b0);
    n_cmp++;
    if (err_uf !== 1'b1 || tos !== 32'd7 || depth !== 3'd1) begin
      n_bad++; $display("FAIL uf_swap: got uf=%b tos=%0d depth=%0d want 1/7/1", err_uf, tos, depth);
    end
    do_cmd(CMD_ROT, '0, 1'b1, 1'b0);
    n_cmp++;
    if (err_uf !== 1'b1 || depth !== 3'd1) begin
      n_bad++; $display("FAIL uf_set_wins: got uf=%b depth=%0d want 1/1", err_uf, depth);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= CAP; i++) do_cmd(CMD_PUSH, DSZ'(i), 1'b0, 1'b0);
    n_cmp++;
    if (depth !== 3'd6 || tos !== 32'd6 || err_of !== 1'b0) begin
      n_bad++; $display("FAIL of_fill: got depth=%0d tos=%0d of=%b want 6/6/0", depth, tos, err_of);
    end
    do_cmd(CMD_PUSH, 32'd7, 1'b0, 1'b0);
    n_cmp++;
    if (err_of !== 1'b1 || tos !== 32'd6 || depth !== 3'd6) begin
      n_bad++; $display("FAIL of_push: got of=%b tos=%0d depth=%0d want 1/6/6", err_of, tos, depth);
    end
    do_cmd(CMD_DROP, '0, 1'b0, 1'b1);
    n_cmp++;
    if (tos !== 32'd5 || nos !== 32'd4 || depth !== 3'd5 || err_of !== 1'b1) begin
      n_bad++; $display("FAIL of_drop: got tos=%0d nos=%0d depth=%0d of=%b want 5/4/5/1",
                        tos, nos, depth, err_of);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int i = 1; i <= 3; i++) do_cmd(CMD_PUSH, DSZ'(i), 1'b0, 1'b0);
    @(negedge clk);
    cif.cmd = CMD_DROP; cif.cmd_vld = 1'b1;
    sbq.push_back('{SS_POP, '0});
    @(negedge clk);
    cif.cmd_vld = 1'b0; cif.cmd = CMD_NOP;
    n_cmp++;
    if (cif.cmd_rdy !== 1'b0) begin n_bad++; $display("FAIL midop_wait: got rdy=%b want 0", cif.cmd_rdy); end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tos !== '0 || nos !== '0 || depth !== '0 || ss_op !== SS_NOP) begin
      n_bad++; $display("FAIL midop_rst: got tos=%0d nos=%0d depth=%0d op=%0d want 0/0/0/0",
                        tos, nos, depth, ss_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    n_cmp++;
    if (cif.cmd_rdy !== 1'b1) begin n_bad++; $display("FAIL midop_rdy: got %b want 1", cif.cmd_rdy); end
    do_cmd(CMD_PUSH, 32'd9, 1'b0, 1'b0);
    n_cmp++;
    if (tos !== 32'd9 || depth !== 3'd1) begin
      n_bad++; $display("FAIL midop_after: got tos=%0d depth=%0d want 9/1", tos, depth);
    end
  endtask

  initial begin
    cif.cmd = CMD_NOP; cif.cmd_vld = 1'b0; cif.lit = '0; err_clr = 1'b0;
    model_clear();
    test_reset();
    test_push_pop();
    test_rot();
    test_reg_words();
    test_underflow();
    test_overflow();
    test_reset_midop();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++; $display("FAIL sb_drain: got %0d pending mem ops want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
